// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_pkg: shared definitions for the spi_reg_bank SPI control-register block.
//   state_e  - frame FSM encoding (IDLE / SHIFT / COMMIT)
//   RW_WRITE - value of the frame's leading R/W bit that requests a write
//   frame_w  - total frame length in bits for a given address/data width
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic RW_WRITE = 1'b1;

  // One R/W bit, then address, then data.
  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_edge_sync.sv
// spi_edge_sync: two-flop synchroniser for an asynchronous input plus one
// history flop for edge detection.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input
//   sync       : synchronised level
//   rise_c     : one-clk pulse on a synchronised 0->1 transition
//   fall_c     : one-clk pulse on a synchronised 1->0 transition
// RST_VAL is the idle level of the input so no false edge appears after reset.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Synchroniser chain and edge-history flop.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync   = sync_q;
  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral holding NUM_REGS control registers of
// DATA_W bits, all logic in the clk domain.
//   clk, rst_n         : system clock, async active-low reset
//   sclk, copi, ncs    : SPI pins from the controller (asynchronous)
//   cipo, cipo_oe      : read-back data and its output enable
//   regs               : flattened registers, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe          : one-clk pulse per register on the cycle it updates
//   frame_err          : one-clk pulse when a frame is rejected
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, MSB first.
// Only frames of exactly FRAME_W bits are accepted. f_clk must be >= 8 x f_sclk.
// Optional macro SPI_READBACK_EN: read frames return regs[addr] on cipo;
// without it cipo and cipo_oe are tied low.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned REGS_W  = NUM_REGS * DATA_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_W + 1);

  logic sclk_rise_c, sclk_fall_c, sclk_sync_unused;
  logic ncs_rise_c, ncs_fall_c, ncs_sync;
  logic copi_sync, copi_rise_unused, copi_fall_unused;

  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (sclk),
    .sync   (sclk_sync_unused),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_ncs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (ncs),
    .sync   (ncs_sync),
    .rise_c (ncs_rise_c),
    .fall_c (ncs_fall_c)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_copi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (copi),
    .sync   (copi_sync),
    .rise_c (copi_rise_unused),
    .fall_c (copi_fall_unused)
  );

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic [REGS_W-1:0]      regs_q, regs_d;
  logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
  logic                   frame_err_q, frame_err_d;

  logic                   cmd_rw;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [DATA_W-1:0]      cmd_data;
  logic [NUM_REGS-1:0]    addr_sel;

  assign cmd_rw   = shift_q[FRAME_W-1];
  assign cmd_addr = shift_q[FRAME_W-2 -: ADDR_W];
  assign cmd_data = shift_q[DATA_W-1:0];

  // One-hot decode of the captured address; all-zero means out of range.
  always_comb begin
    addr_sel = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      addr_sel[k] = (ADDR_W'(k) == cmd_addr);
    end
  end

  // Frame FSM: capture in SHIFT, validate and apply in the single COMMIT cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ncs_fall_c) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise_c) begin
          shift_d = {shift_q[FRAME_W-2:0], copi_sync};
          // Saturating count: CNT_OVF flags any frame longer than FRAME_W.
          if (bit_cnt_q != CNT_OVF) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (ncs_rise_c) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (bit_cnt_q != CNT_FULL) begin
          frame_err_d = 1'b1;
        end else if (cmd_rw == RW_WRITE) begin
          if (addr_sel == '0) begin
            frame_err_d = 1'b1;
          end else begin
            wr_strobe_d = addr_sel;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
              if (addr_sel[k]) begin
                regs_d[k*DATA_W +: DATA_W] = cmd_data;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      regs_q      <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign regs      = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] out_shift_q, out_shift_d;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;

  // Address is complete in shift_d on the rise that captures its last bit.
  assign rd_addr = shift_d[ADDR_W-1:0];

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (ADDR_W'(k) == rd_addr) begin
        rd_data = regs_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Load on the last address bit of a read; the fall right after that rise is
  // skipped so the MSB is still present for the controller's next rising edge.
  always_comb begin
    out_shift_d = out_shift_q;
    if (state_q != SHIFT) begin
      out_shift_d = '0;
    end else if (sclk_rise_c && (bit_cnt_q == CNT_W'(ADDR_W))) begin
      out_shift_d = (shift_d[ADDR_W] == RW_WRITE) ? '0 : rd_data;
    end else if (sclk_fall_c && (bit_cnt_q > CNT_W'(ADDR_W + 1))) begin
      out_shift_d = {out_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_shift_q <= '0;
    end else begin
      out_shift_q <= out_shift_d;
    end
  end

  assign cipo    = out_shift_q[DATA_W-1];
  assign cipo_oe = ~ncs_sync;
`else
  logic ncs_sync_unused;
  assign ncs_sync_unused = ncs_sync;
  assign cipo            = 1'b0;
  assign cipo_oe         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank at default parameters. A behavioural
// register-array model predicts register contents, strobes, errors and
// read-back data for directed and randomised SPI frames.
module tb_spi_reg_bank;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int FRAME_W  = 16;
  localparam int REGS_W   = NUM_REGS * DATA_W;
`ifdef SPI_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs = 1'b1;
  logic cipo, cipo_oe, frame_err;
  logic [REGS_W-1:0]   regs;
  logic [NUM_REGS-1:0] wr_strobe;

  spi_reg_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state and per-frame expectations.
  logic [DATA_W-1:0]   model [NUM_REGS];
  logic [REGS_W-1:0]   exp_pre;
  logic [NUM_REGS-1:0] exp_strobe;
  int                  exp_err;
  logic [DATA_W-1:0]   exp_rb;

  // Observations collected while a frame is driven.
  logic [NUM_REGS-1:0] obs_strobe_or;
  int                  obs_strobe_cnt;
  int                  obs_strobe_cyc;
  int                  obs_err_cnt;
  logic [REGS_W-1:0]   obs_regs_pre;
  logic [DATA_W-1:0]   obs_rb;
  logic                obs_oe;
  logic                obs_cmd_cipo;

  function automatic logic [REGS_W-1:0] flat_model();
    logic [REGS_W-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = model[k];
    return v;
  endfunction

  // Apply one frame to the model using the frame rules directly.
  task automatic model_frame(input logic [31:0] word, input int nbits);
    logic rw;
    int addr;
    logic [DATA_W-1:0] data;
    exp_pre    = flat_model();
    exp_strobe = '0;
    exp_err    = 0;
    exp_rb     = '0;
    if (nbits != FRAME_W) begin
      exp_err = 1;
    end else begin
      rw   = word[FRAME_W-1];
      addr = int'(word[FRAME_W-2 -: ADDR_W]);
      data = word[DATA_W-1:0];
      if (rw) begin
        if (addr < NUM_REGS) begin
          model[addr]      = data;
          exp_strobe[addr] = 1'b1;
        end else begin
          exp_err = 1;
        end
      end else if (RB_EN && addr < NUM_REGS) begin
        exp_rb = model[addr];
      end
    end
  endtask

  // Drive one frame of nbits (low bits of word, MSB first) with sclk = clk/8,
  // then watch 8 clks after ncs rises.
  task automatic run_frame(input logic [31:0] word, input int nbits);
    obs_rb = '0; obs_oe = 1'b0; obs_cmd_cipo = 1'b0;
    obs_strobe_or = '0; obs_strobe_cnt = 0; obs_strobe_cyc = 0; obs_err_cnt = 0;
    @(negedge clk);
    ncs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      copi = word[nbits-1-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (i == 0) obs_oe = cipo_oe;
      if (i < 1 + ADDR_W) obs_cmd_cipo = obs_cmd_cipo | cipo;
      else if (i < FRAME_W) obs_rb[FRAME_W-1-i] = cipo;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ncs  = 1'b1;
    copi = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (wr_strobe != '0) begin
        obs_strobe_cnt++;
        obs_strobe_or = obs_strobe_or | wr_strobe;
        if (obs_strobe_cyc == 0) obs_strobe_cyc = c;
      end
      if (frame_err) obs_err_cnt++;
      if (c == 3) obs_regs_pre = regs;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (regs !== '0) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs); end
    checks++; if (wr_strobe !== '0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (cipo !== 1'b0) begin errors++; $display("FAIL reset_cipo: got %b expected 0", cipo); end
    checks++; if (cipo_oe !== 1'b0) begin errors++; $display("FAIL reset_cipo_oe: got %b expected 0", cipo_oe); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [DATA_W-1:0] r0;
    model_frame(32'h80A5, 16);
    run_frame(32'h80A5, 16);
    r0 = regs[0 +: DATA_W];
    checks++; if (r0 !== 8'hA5) begin errors++; $display("FAIL single_reg0: got %h expected a5", r0); end
    checks++; if (obs_strobe_or !== 5'b00001) begin errors++; $display("FAIL single_strobe: got %b expected 00001", obs_strobe_or); end
    checks++; if (obs_strobe_cnt !== 1) begin errors++; $display("FAIL single_strobe_len: got %0d expected 1", obs_strobe_cnt); end
    checks++; if (obs_strobe_cyc !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", obs_strobe_cyc); end
    checks++; if (obs_regs_pre !== exp_pre) begin errors++; $display("FAIL single_pre: got %h expected %h", obs_regs_pre, exp_pre); end
    checks++; if (regs !== flat_model()) begin errors++; $display("FAIL single_regs: got %h expected %h", regs, flat_model()); end
    checks++; if (obs_err_cnt !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", obs_err_cnt); end
  endtask

  task automatic test_two_writes();
    model_frame(32'h843C, 16);
    run_frame(32'h843C, 16);
    checks++; if (obs_strobe_or !== 5'b10000 || obs_strobe_cnt !== 1) begin
      errors++; $display("FAIL two_strobe4: got %b x%0d expected 10000 x1", obs_strobe_or, obs_strobe_cnt); end
    model_frame(32'h8255, 16);
    run_frame(32'h8255, 16);
    checks++; if (obs_strobe_or !== 5'b00100 || obs_strobe_cnt !== 1) begin
      errors++; $display("FAIL two_strobe2: got %b x%0d expected 00100 x1", obs_strobe_or, obs_strobe_cnt); end
    checks++; if (regs !== flat_model()) begin errors++; $display("FAIL two_regs: got %h expected %h", regs, flat_model()); end
    checks++; if (obs_err_cnt !== 0) begin errors++; $display("FAIL two_err: got %0d expected 0", obs_err_cnt); end
  endtask

  task automatic test_bad_addr();
    model_frame(32'h87FF, 16);
    run_frame(32'h87FF, 16);
    checks++; if (obs_strobe_cnt !== 0) begin errors++; $display("FAIL badaddr_strobe: got %0d expected 0", obs_strobe_cnt); end
    checks++; if (obs_err_cnt !== 1) begin errors++; $display("FAIL badaddr_err: got %0d expected 1", obs_err_cnt); end
    checks++; if (regs !== flat_model()) begin errors++; $display("FAIL badaddr_regs: got %h expected %h", regs, flat_model()); end
  endtask

  task automatic test_bad_length();
    model_frame(32'h407F, 15);
    run_frame(32'h407F, 15);
    checks++; if (obs_err_cnt !== 1 || obs_strobe_cnt !== 0) begin
      errors++; $display("FAIL len15: got err=%0d strobe=%0d expected err=1 strobe=0", obs_err_cnt, obs_strobe_cnt); end
    model_frame(32'h101FF, 17);
    run_frame(32'h101FF, 17);
    checks++; if (obs_err_cnt !== 1 || obs_strobe_cnt !== 0) begin
      errors++; $display("FAIL len17: got err=%0d strobe=%0d expected err=1 strobe=0", obs_err_cnt, obs_strobe_cnt); end
    checks++; if (regs !== flat_model()) begin errors++; $display("FAIL len_regs: got %h expected %h", regs, flat_model()); end
  endtask

  task automatic test_readback();
    model_frame(32'h0400, 16);
    run_frame(32'h0400, 16);
    checks++; if (obs_rb !== exp_rb) begin errors++; $display("FAIL rb_addr4: got %h expected %h", obs_rb, exp_rb); end
    checks++; if (obs_oe !== RB_EN) begin errors++; $display("FAIL rb_oe: got %b expected %b", obs_oe, RB_EN); end
    checks++; if (obs_cmd_cipo !== 1'b0) begin errors++; $display("FAIL rb_cmd_cipo: got %b expected 0", obs_cmd_cipo); end
    checks++; if (obs_err_cnt !== 0 || obs_strobe_cnt !== 0) begin
      errors++; $display("FAIL rb_side_effect: got err=%0d strobe=%0d expected 0 0", obs_err_cnt, obs_strobe_cnt); end
    model_frame(32'h0600, 16);
    run_frame(32'h0600, 16);
    checks++; if (obs_rb !== 8'h00) begin errors++; $display("FAIL rb_addr6: got %h expected 00", obs_rb); end
    checks++; if (regs !== flat_model()) begin errors++; $display("FAIL rb_regs: got %h expected %h", regs, flat_model()); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] word;
    int strobes, errs;
    word = 32'h8333;
    strobes = 0; errs = 0;
    @(negedge clk);
    ncs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      copi = word[15-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    repeat (3) @(negedge clk);
    checks++; if (regs !== '0) begin errors++; $display("FAIL midrst_regs: got %h expected 0", regs); end
    ncs = 1'b1; copi = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_strobe != '0) strobes++;
      if (frame_err) errs++;
    end
    checks++; if (strobes !== 0 || errs !== 0) begin
      errors++; $display("FAIL midrst_pulses: got strobe=%0d err=%0d expected 0 0", strobes, errs); end
    checks++; if (regs !== '0) begin errors++; $display("FAIL midrst_after: got %h expected 0", regs); end
    model_frame(32'h8111, 16);
    run_frame(32'h8111, 16);
    checks++; if (regs !== flat_model()) begin errors++; $display("FAIL midrst_write: got %h expected %h", regs, flat_model()); end
    checks++; if (obs_strobe_or !== 5'b00010) begin errors++; $display("FAIL midrst_strobe: got %b expected 00010", obs_strobe_or); end
  endtask

  task automatic test_random();
    logic [31:0] word;
    logic [15:0] base;
    int nbits, sel;
    for (int n = 0; n < 40; n++) begin
      base = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
      sel  = $urandom_range(0, 9);
      if (sel == 0) begin
        nbits = 15; word = 32'(base >> 1);
      end else if (sel == 1) begin
        nbits = 17; word = {15'd0, base, 1'($urandom)};
      end else if (sel == 2) begin
        nbits = $urandom_range(1, 14); word = 32'(base >> (16 - nbits));
      end else begin
        nbits = 16; word = {16'd0, base};
      end
      model_frame(word, nbits);
      run_frame(word, nbits);
      checks++; if (obs_strobe_or !== exp_strobe) begin
        errors++; $display("FAIL rnd%0d_strobe: got %b expected %b (frame %h/%0d)", n, obs_strobe_or, exp_strobe, word, nbits); end
      checks++; if (obs_strobe_cnt !== ((exp_strobe != '0) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_strobe_len: got %0d", n, obs_strobe_cnt); end
      checks++; if (obs_err_cnt !== exp_err) begin
        errors++; $display("FAIL rnd%0d_err: got %0d expected %0d (frame %h/%0d)", n, obs_err_cnt, exp_err, word, nbits); end
      checks++; if (obs_regs_pre !== exp_pre) begin
        errors++; $display("FAIL rnd%0d_pre: got %h expected %h", n, obs_regs_pre, exp_pre); end
      checks++; if (regs !== flat_model()) begin
        errors++; $display("FAIL rnd%0d_regs: got %h expected %h", n, regs, flat_model()); end
      checks++; if (obs_cmd_cipo !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_cmd_cipo: got %b expected 0", n, obs_cmd_cipo); end
      if (exp_strobe != '0) begin
        checks++; if (obs_strobe_cyc !== 4) begin
          errors++; $display("FAIL rnd%0d_latency: got %0d expected 4", n, obs_strobe_cyc); end
      end
      if (nbits == FRAME_W) begin
        checks++; if (obs_rb !== exp_rb) begin
          errors++; $display("FAIL rnd%0d_rb: got %h expected %h (frame %h)", n, obs_rb, exp_rb, word); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_two_writes();
    test_bad_addr();
    test_bad_length();
    test_readback();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
